alu_seq: RTL and testbench

//  Parametrised successor to the single-cycle datapath ALU. Keeps the ALUFun

---
 rtl/alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: EX-stage ALU. Single-cycle ALUFun ops plus an iterative radix-2
// multiply/divide unit producing Hi/Lo, with valid/ready handshakes.
// Optional feature macro: ALU_OVF_EN (drives Ovf with signed add/sub overflow).
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    input  logic [5:0]       ALUFun,
    input  logic             Md,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero,
    output logic             Ovf
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   z_q, z_d, hi_q, hi_d, lo_q, lo_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   acc_q, acc_d, wrk_q, wrk_d, dvs_q, dvs_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic               sgn_q, sgn_d, div_q, div_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_z_c;
    logic               cmp_bit, lt_bit, a_neg, a_zero;
    logic [SHW-1:0]     shamt;
    logic               accept_alu;

    assign in_ready   = (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign accept_alu = in_valid & in_ready & ~Md;
    assign out_valid  = out_valid_q;
    assign Z          = z_q;
    assign Hi         = hi_q;
    assign Lo         = lo_q;
    assign DivZero    = dz_q;
    assign shamt      = A[SHW-1:0];
    assign a_neg      = A[WIDTH-1];
    assign a_zero     = (A == '0);
    assign lt_bit     = Sign ? ($signed(A) < $signed(B)) : (A < B);

    // Single-cycle result for arith/logic/shift/compare codes
    always_comb begin
        alu_z_c = '0;
        cmp_bit = 1'b0;
        case (ALUFun[3:1])
            3'b001:  cmp_bit = (A == B);
            3'b000:  cmp_bit = (A != B);
            3'b010:  cmp_bit = lt_bit;
            3'b110:  cmp_bit = a_neg | a_zero;
            3'b101:  cmp_bit = a_neg;
            3'b111:  cmp_bit = ~a_neg & ~a_zero;
            default: cmp_bit = 1'b0;
        endcase
        case (ALUFun[5:4])
            2'b00: alu_z_c = ALUFun[0] ? (A - B) : (A + B);
            2'b01: begin
                case (ALUFun[3:0])
                    4'b1000: alu_z_c = A & B;
                    4'b1110: alu_z_c = A | B;
                    4'b0110: alu_z_c = A ^ B;
                    4'b0001: alu_z_c = ~(A | B);
                    4'b1010: alu_z_c = A;
                    default: alu_z_c = '0;
                endcase
            end
            2'b10: begin
                case (ALUFun[1:0])
                    2'b00:   alu_z_c = B << shamt;
                    2'b01:   alu_z_c = B >> shamt;
                    2'b11:   alu_z_c = WIDTH'($signed(B) >>> shamt);
                    default: alu_z_c = '0;
                endcase
            end
            default: alu_z_c = {{(WIDTH-1){1'b0}}, cmp_bit};
        endcase
    end

    // Next-state, mul/div datapath and result capture
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~out_ready;
        z_d   = z_q;   hi_d  = hi_q;  lo_d  = lo_q;  dz_d = dz_q;
        acc_d = acc_q; wrk_d = wrk_q; dvs_d = dvs_q;
        opa_d = opa_q; opb_d = opb_q; sgn_d = sgn_q; div_d = div_q;
        sa_d  = sa_q;  sb_d  = sb_q;  bz_d  = bz_q;  cnt_d = cnt_q;
        mul_sum  = '0;
        div_sh   = '0;
        div_diff = '0;
        prod     = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    if (Md) begin
                        state_d     = S_LOAD;
                        out_valid_d = 1'b0;
                        opa_d = A;
                        opb_d = B;
                        sgn_d = Sign;
                        div_d = ALUFun[0];
                    end else begin
                        out_valid_d = 1'b1;
                        z_d         = alu_z_c;
                    end
                end
            end
            S_LOAD: begin
                sa_d  = sgn_q & opa_q[WIDTH-1];
                sb_d  = sgn_q & opb_q[WIDTH-1];
                wrk_d = (sgn_q & opa_q[WIDTH-1]) ? -opa_q : opa_q;
                dvs_d = (sgn_q & opb_q[WIDTH-1]) ? -opb_q : opb_q;
                bz_d  = (opb_q == '0);
                acc_d = '0;
                cnt_d = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!div_q) begin
                    mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, dvs_q} : '0);
                    acc_d   = mul_sum[WIDTH:1];
                    wrk_d   = {mul_sum[0], wrk_q[WIDTH-1:1]};
                end else if (!bz_q) begin
                    div_sh   = {acc_q, wrk_q[WIDTH-1]};
                    div_diff = div_sh - {1'b0, dvs_q};
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh[WIDTH-1:0];
                        wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                out_valid_d = 1'b1;
                state_d     = S_DONE;
                if (div_q) begin
                    if (bz_q) begin
                        lo_d = '1;
                        hi_d = opa_q;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? -wrk_q : wrk_q;
                        hi_d = sa_q ? -acc_q : acc_q;
                        dz_d = 1'b0;
                    end
                end else begin
                    prod = {acc_q, wrk_q};
                    if (sa_q ^ sb_q) prod = -prod;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                    dz_d = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE; out_valid_q <= 1'b0;
            z_q   <= '0; hi_q  <= '0; lo_q  <= '0; dz_q <= 1'b0;
            acc_q <= '0; wrk_q <= '0; dvs_q <= '0;
            opa_q <= '0; opb_q <= '0; sgn_q <= 1'b0; div_q <= 1'b0;
            sa_q  <= 1'b0; sb_q <= 1'b0; bz_q <= 1'b0; cnt_q <= '0;
        end else begin
            state_q <= state_d; out_valid_q <= out_valid_d;
            z_q   <= z_d;   hi_q  <= hi_d;  lo_q  <= lo_d;  dz_q <= dz_d;
            acc_q <= acc_d; wrk_q <= wrk_d; dvs_q <= dvs_d;
            opa_q <= opa_d; opb_q <= opb_d; sgn_q <= sgn_d; div_q <= div_d;
            sa_q  <= sa_d;  sb_q  <= sb_d;  bz_q  <= bz_d;  cnt_q <= cnt_d;
        end
    end

`ifdef ALU_OVF_EN
    logic             ovf_q, ovf_d, alu_ovf_c;
    logic [WIDTH-1:0] ovf_res;

    // Signed add/sub overflow, captured alongside Z
    always_comb begin
        alu_ovf_c = 1'b0;
        ovf_res   = ALUFun[0] ? (A - B) : (A + B);
        if (Sign && (ALUFun[5:4] == 2'b00)) begin
            if (ALUFun[0]) alu_ovf_c = (A[WIDTH-1] != B[WIDTH-1]) && (ovf_res[WIDTH-1] != A[WIDTH-1]);
            else           alu_ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (ovf_res[WIDTH-1] != A[WIDTH-1]);
        end
        ovf_d = accept_alu ? alu_ovf_c : ovf_q;
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level reference model of alu_seq (WIDTH=32).
module tb_alu_seq;
    localparam int unsigned W = 32;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;
`ifdef ALU_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0, rst_n = 1'b1;
    logic         in_valid = 1'b0, Sign = 1'b0, Md = 1'b0, out_ready = 1'b1;
    logic [W-1:0] A = '0, B = '0;
    logic [5:0]   ALUFun = '0;
    logic         in_ready, out_valid, DivZero, Ovf;
    logic [W-1:0] Z, Hi, Lo;

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0, rand_or = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Sign(Sign), .ALUFun(ALUFun), .Md(Md),
        .out_valid(out_valid), .out_ready(out_ready), .Z(Z), .Hi(Hi), .Lo(Lo),
        .DivZero(DivZero), .Ovf(Ovf)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: single-cycle op, returns {ovf, z}
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, b, input logic s, input logic [5:0] f);
        logic [W-1:0] z;
        logic ovf;
        longint sa, sb, r;
        int sh;
        sa = $signed(a); sb = $signed(b); sh = int'(a[4:0]);
        z = '0; ovf = 1'b0;
        case (f[5:4])
            2'b00: begin
                r   = f[0] ? sa - sb : sa + sb;
                z   = f[0] ? a - b : a + b;
                ovf = OVF_ON && s && (r > SMAX || r < SMIN);
            end
            2'b01: case (f[3:0])
                4'b1000: z = a & b;
                4'b1110: z = a | b;
                4'b0110: z = a ^ b;
                4'b0001: z = ~(a | b);
                4'b1010: z = a;
                default: z = '0;
            endcase
            2'b10: case (f[1:0])
                2'b00:   z = b << sh;
                2'b01:   z = b >> sh;
                2'b11:   z = W'($signed(b) >>> sh);
                default: z = '0;
            endcase
            default: case (f[3:1])
                3'b001:  z = W'(a == b);
                3'b000:  z = W'(a != b);
                3'b010:  z = s ? W'(sa < sb) : W'(a < b);
                3'b110:  z = W'(sa <= 0);
                3'b101:  z = W'(sa < 0);
                3'b111:  z = W'(sa > 0);
                default: z = '0;
            endcase
        endcase
        return {ovf, z};
    endfunction

    // Reference: mul/div op, returns {divzero, hi, lo}
    function automatic logic [2*W:0] md_ref(input logic [W-1:0] a, b, input logic s, input logic dv);
        logic [2*W-1:0] p;
        longint sa, sb, q, r;
        sa = $signed(a); sb = $signed(b);
        if (!dv) begin
            if (s) p = sa * sb;
            else   p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (s) begin
            q = sa / sb; r = sa % sb;
            return {1'b0, r[W-1:0], q[W-1:0]};
        end
        return {1'b0, a % b, a / b};
    endfunction

    // Cycle-level expectation: results appear 1 edge (ALU) or W+2 edges (Md) after acceptance
    logic         m_valid = 0, m_dz = 0, m_ovf = 0, m_hold = 0;
    logic [W-1:0] m_z = '0, m_hi = '0, m_lo = '0;
    logic [2*W:0] p_res = '0;
    int           m_busy = 0;

    function automatic logic m_ready();
        return (m_busy == 0) && !m_hold && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_z = '0; m_hi = '0; m_lo = '0; m_dz = 0; m_ovf = 0;
            m_busy = 0; m_hold = 0;
        end else if (m_busy != 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1; m_hold = 1;
                {m_dz, m_hi, m_lo} = p_res;
            end
        end else if (m_hold) begin
            if (out_ready) begin m_hold = 0; m_valid = 0; end
        end else if (in_valid && m_ready()) begin
            if (Md) begin
                m_busy  = W + 2;
                m_valid = 0;
                p_res   = md_ref(A, B, Sign, ALUFun[0]);
            end else begin
                m_valid = 1;
                {m_ovf, m_z} = alu_ref(A, B, Sign, ALUFun);
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  W'(in_ready),  W'(m_ready()));
            chk("out_valid", W'(out_valid), W'(m_valid));
            chk("Z",  Z,  m_z);
            chk("Hi", Hi, m_hi);
            chk("Lo", Lo, m_lo);
            chk("DivZero", W'(DivZero), W'(m_dz));
            chk("Ovf", W'(Ovf), W'(m_ovf));
        end
    end

    // Random consumer back-pressure during the random phase
    always @(posedge clk) begin
        #1;
        if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic drive_op(input logic md, input logic [5:0] f, input logic s,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic rdy;
        int t;
        Md = md; ALUFun = f; Sign = s; A = a; B = b; in_valid = 1'b1; t = 0;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1; t++;
        end while (!rdy && t < 200);
        if (!rdy) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, want 1", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return W'($urandom_range(0, 31));
            default: return W'($urandom);
        endcase
    endfunction

    logic [5:0]   funs [18];
    logic [W:0]   ar;
    logic [2*W:0] mr;
    int           n;

    initial begin
        funs = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                 6'b011010, 6'b010011, 6'b100000, 6'b100001, 6'b100011, 6'b100010,
                 6'b110010, 6'b110000, 6'b110100, 6'b111100, 6'b111010, 6'b111110};
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", W'(in_ready), 32'h1);
        chk("rst_out_valid", W'(out_valid), 32'h0);
        chk("rst_Hi", Hi, 32'h0);

        // Hand-computed pins on the reference model
        ar = alu_ref(32'h7FFFFFFF, 32'h1, 1'b1, 6'b000000);
        chk("ref_add", ar[W-1:0], 32'h80000000);
        ar = alu_ref(32'h4, 32'h80000010, 1'b0, 6'b100011);
        chk("ref_sra", ar[W-1:0], 32'hF8000001);
        mr = md_ref(32'hFFFFFFFD, 32'h7, 1'b1, 1'b0);
        chk("ref_mul_hi", mr[2*W-1:W], 32'hFFFFFFFF);
        chk("ref_mul_lo", mr[W-1:0], 32'hFFFFFFEB);
        mr = md_ref(32'hFFFFFFF9, 32'h2, 1'b1, 1'b1);
        chk("ref_div_lo", mr[W-1:0], 32'hFFFFFFFD);
        chk("ref_div_hi", mr[2*W-1:W], 32'hFFFFFFFF);

        // Overflowing add, SRA, signed/unsigned LT back to back
        drive_op(1'b0, 6'b000000, 1'b1, 32'h7FFFFFFF, 32'h1);
        chk("add_z", Z, 32'h80000000);
        chk("add_valid", W'(out_valid), 32'h1);
        chk("add_ovf", W'(Ovf), W'(OVF_ON));
        drive_op(1'b0, 6'b100011, 1'b0, 32'h4, 32'h80000010);
        chk("sra_z", Z, 32'hF8000001);
        drive_op(1'b0, 6'b110100, 1'b1, 32'hFFFFFFFF, 32'h1);
        chk("lt_signed", Z, 32'h1);
        drive_op(1'b0, 6'b110100, 1'b0, 32'hFFFFFFFF, 32'h1);
        chk("lt_unsigned", Z, 32'h0);

        // Signed multiply latency and result
        drive_op(1'b1, 6'b000000, 1'b1, 32'hFFFFFFFD, 32'h7);
        wait_valid(n);
        chk("mul_latency", W'(n), 32'd34);
        chk("mul_hi", Hi, 32'hFFFFFFFF);
        chk("mul_lo", Lo, 32'hFFFFFFEB);

        // Divides: signed, by zero, MIN/-1
        drive_op(1'b1, 6'b000001, 1'b1, 32'hFFFFFFF9, 32'h2);
        wait_valid(n);
        chk("div_lo", Lo, 32'hFFFFFFFD);
        chk("div_hi", Hi, 32'hFFFFFFFF);
        drive_op(1'b1, 6'b000001, 1'b0, 32'h5, 32'h0);
        wait_valid(n);
        chk("div0_latency", W'(n), 32'd34);
        chk("div0_lo", Lo, 32'hFFFFFFFF);
        chk("div0_hi", Hi, 32'h5);
        chk("div0_flag", W'(DivZero), 32'h1);
        drive_op(1'b1, 6'b000001, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_valid(n);
        chk("minneg1_lo", Lo, 32'h80000000);
        chk("minneg1_hi", Hi, 32'h0);
        chk("minneg1_dz", W'(DivZero), 32'h0);

        // Back-pressure: result held, next op stalled until out_ready
        drive_op(1'b0, 6'b000000, 1'b0, 32'd10, 32'd20);
        out_ready = 1'b0;
        Md = 1'b0; ALUFun = 6'b000000; Sign = 1'b0; A = 32'd1; B = 32'd1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_z", Z, 32'd30);
            chk("hold_in_ready", W'(in_ready), 32'h0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", W'(in_ready), 32'h1);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("release_z", Z, 32'd2);

        // Reset in the middle of a divide
        drive_op(1'b1, 6'b000000, 1'b1, 32'hFFFFFFFF, 32'h5);
        wait_valid(n);
        drive_op(1'b1, 6'b000001, 1'b0, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), 32'h0);
        chk("mid_rst_hi", Hi, 32'h0);
        chk("mid_rst_lo", Lo, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive_op(1'b0, 6'b000000, 1'b0, 32'd2, 32'd3);
        chk("post_rst_add", Z, 32'd5);

        // Randomized traffic with random back-pressure
        rand_or = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic md;
            md = ($urandom_range(0, 4) == 0);
            drive_op(md, md ? {5'b0, 1'($urandom)} : funs[$urandom_range(0, 17)],
                     1'($urandom), rnd_opnd(), rnd_opnd());
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_or = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
